// File: rtl/issue_ctrl_pkg.sv
// Shared definitions for the R-type issue controller: opcodes, instruction
// field positions, scoreboard entry type and the opcode/func legality check.
package issue_ctrl_pkg;

  localparam logic [6:0] OP_ARITH = 7'h01;
  localparam logic [6:0] OP_SHIFT = 7'h03;
  localparam logic [6:0] OP_CMP   = 7'h07;
  localparam logic [6:0] OP_LOGIC = 7'h0F;

  localparam int OPC_LSB  = 0;
  localparam int OPC_MSB  = 6;
  localparam int RD_LSB   = 7;
  localparam int RD_MSB   = 11;
  localparam int FUNC_LSB = 12;
  localparam int FUNC_MSB = 14;
  localparam int RS1_LSB  = 15;
  localparam int RS1_MSB  = 19;
  localparam int RS2_LSB  = 20;
  localparam int RS2_MSB  = 24;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
  } sb_entry_t;

  function automatic logic is_legal(input logic [6:0] opcode, input logic [2:0] func);
    logic legal_s;
    case (opcode)
      OP_ARITH: legal_s = (func <= 3'd1);
      OP_SHIFT: legal_s = (func <= 3'd2);
      OP_CMP:   legal_s = (func <= 3'd1);
      OP_LOGIC: legal_s = (func <= 3'd2);
      default:  legal_s = 1'b0;
    endcase
    return legal_s;
  endfunction

endpackage

// File: rtl/issue_fifo.sv
// Synchronous instruction buffer with flush; head entry is visible
// combinationally on rd_data whenever the buffer is not empty.
module issue_fifo
  import issue_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;

  assign full    = (count_r == DEPTH_CNT);
  assign empty   = (count_r == '0);
  assign rd_data = mem_r[rd_ptr_r];

  // Pointer and occupancy tracking; flush discards every buffered entry.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are meaningless while the count says empty.
  always_ff @(posedge clk) begin
    if (push) mem_r[wr_ptr_r] <= wr_data;
  end

endmodule

// File: rtl/instr_issue_ctrl.sv
// Issue controller: buffers instructions, drops illegal ones and stalls RAW
// hazards against a shifting destination scoreboard. ISSUE_PERF_CNT_EN adds counters.
module instr_issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter int          PIPE_DEPTH = 3,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        run,
  input  logic        flush,
  output logic        issue_valid,
  output logic [31:0] issue_instr,
  output logic        stall,
  output logic        illegal_drop,
  output logic        idle
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0] issued_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] drop_cnt
`endif
);

  logic [31:0] head_s;
  logic        empty_s, full_s, push_s, pop_s;
  logic        legal_s, hazard_s, sb_any_s;
  logic        fire_s, drop_s, blocked_s;
  logic [4:0]  head_rd_s, head_rs1_s, head_rs2_s;
  sb_entry_t   sb_r [PIPE_DEPTH];
  logic        issue_valid_r, stall_r, drop_r;
  logic [31:0] issue_instr_r;

  // Flush takes precedence over a same-cycle push.
  assign push_s   = in_valid & ~full_s & ~flush;
  assign pop_s    = fire_s | drop_s;
  assign in_ready = ~full_s;

  issue_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_s),
    .pop     (pop_s),
    .flush   (flush),
    .wr_data (in_instr),
    .rd_data (head_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  assign head_rd_s  = head_s[RD_MSB:RD_LSB];
  assign head_rs1_s = head_s[RS1_MSB:RS1_LSB];
  assign head_rs2_s = head_s[RS2_MSB:RS2_LSB];
  assign legal_s    = is_legal(head_s[OPC_MSB:OPC_LSB], head_s[FUNC_MSB:FUNC_LSB]);

  // Source-vs-busy-destination comparison across all scoreboard slots (x0 included).
  always_comb begin
    hazard_s = 1'b0;
    sb_any_s = 1'b0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      if (sb_r[i].v) begin
        sb_any_s = 1'b1;
        if ((sb_r[i].rd == head_rs1_s) || (sb_r[i].rd == head_rs2_s)) hazard_s = 1'b1;
        else hazard_s = hazard_s;
      end else begin
        sb_any_s = sb_any_s;
      end
    end
  end

  // Head decision: priority is hold, illegal drop, hazard stall, issue.
  always_comb begin
    fire_s    = 1'b0;
    drop_s    = 1'b0;
    blocked_s = 1'b0;
    if (flush || empty_s || !run) begin
      fire_s = 1'b0;
    end else if (!legal_s) begin
      drop_s = 1'b1;
    end else if (hazard_s) begin
      blocked_s = 1'b1;
    end else begin
      fire_s = 1'b1;
    end
  end

  // Registered issue-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid_r <= 1'b0;
      issue_instr_r <= NOP_INSTR;
      stall_r       <= 1'b0;
      drop_r        <= 1'b0;
    end else begin
      issue_valid_r <= fire_s;
      issue_instr_r <= fire_s ? head_s : NOP_INSTR;
      stall_r       <= blocked_s;
      drop_r        <= drop_s;
    end
  end

  // Destination scoreboard shifts every cycle, independent of flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_DEPTH; i++) sb_r[i] <= '{v: 1'b0, rd: 5'd0};
    end else begin
      sb_r[0] <= '{v: fire_s, rd: head_rd_s};
      for (int i = 1; i < PIPE_DEPTH; i++) sb_r[i] <= sb_r[i-1];
    end
  end

  assign issue_valid  = issue_valid_r;
  assign issue_instr  = issue_instr_r;
  assign stall        = stall_r;
  assign illegal_drop = drop_r;
  assign idle         = empty_s & ~sb_any_s;

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] issued_cnt_r, stall_cnt_r, drop_cnt_r;

  // Event counters wrap naturally and survive flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      issued_cnt_r <= 32'd0;
      stall_cnt_r  <= 32'd0;
      drop_cnt_r   <= 32'd0;
    end else begin
      if (fire_s)    issued_cnt_r <= issued_cnt_r + 32'd1;
      if (blocked_s) stall_cnt_r  <= stall_cnt_r + 32'd1;
      if (drop_s)    drop_cnt_r   <= drop_cnt_r + 32'd1;
    end
  end

  assign issued_cnt = issued_cnt_r;
  assign stall_cnt  = stall_cnt_r;
  assign drop_cnt   = drop_cnt_r;
`endif

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Scoreboard bench for instr_issue_ctrl: directed stimulus pushes expected
// issues into a queue, a negedge monitor pops and compares.
module tb_instr_issue_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] ADD = 32'h0010_0401;
  localparam logic [31:0] XOR = 32'h0031_050F;
  localparam logic [31:0] SUB = 32'h0014_1481;
  localparam logic [31:0] ILL = 32'h0000_0005;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, run, flush;
  logic        issue_valid, stall, illegal_drop, idle;
  logic [31:0] in_instr, issue_instr;
`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] issued_cnt, stall_cnt, drop_cnt;
`endif

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          stall_obs = 0;
  int          drop_obs = 0;
  int          drop_cyc = 0;
  logic [31:0] exp_q[$];
  int          issue_cyc_q[$];

  always #5 clk = ~clk;

  instr_issue_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .run          (run),
    .flush        (flush),
    .issue_valid  (issue_valid),
    .issue_instr  (issue_instr),
    .stall        (stall),
    .illegal_drop (illegal_drop),
    .idle         (idle)
`ifdef ISSUE_PERF_CNT_EN
    ,
    .issued_cnt   (issued_cnt),
    .stall_cnt    (stall_cnt),
    .drop_cnt     (drop_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [2:0] f, input logic [4:0] rs1,
                                     input logic [4:0] rs2);
    return {7'd0, rs2, rs1, f, rd, op};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    step();
    while (!idle && n < 60) begin
      step();
      n++;
    end
    if (!idle) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: idle still %b after %0d cycles", idle, n);
    end
    step();
  endtask

  task automatic push(input logic [31:0] instr, input bit expect_issue);
    in_valid = 1'b1;
    in_instr = instr;
    if (expect_issue) exp_q.push_back(instr);
    step();
  endtask

  task automatic clear_obs();
    issue_cyc_q.delete();
    stall_obs = 0;
    drop_obs  = 0;
    drop_cyc  = 0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor: every issue must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (issue_valid) begin
          issue_cyc_q.push_back(cyc);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_issue: got %h expected no issue (cycle %0d)", issue_instr, cyc);
          end else begin
            chk("issue_instr", issue_instr, exp_q.pop_front());
          end
        end else begin
          chk("nop_when_invalid", issue_instr, NOP);
        end
        if (stall) stall_obs++;
        if (illegal_drop) begin
          drop_obs++;
          drop_cyc = cyc;
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_instr = 32'd0; run = 1'b0; flush = 1'b0;
    step();
    step();
    chk("rst_issue_valid", {31'd0, issue_valid}, 32'd0);
    chk("rst_issue_instr", issue_instr, NOP);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_illegal_drop", {31'd0, illegal_drop}, 32'd0);
    chk("rst_idle", {31'd0, idle}, 32'd1);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    step();

    // 1: independent instructions issue back-to-back
    clear_obs();
    run = 1'b1;
    push(ADD, 1'b1);
    push(XOR, 1'b1);
    in_valid = 1'b0;
    wait_idle();
    chk("t1_issue_count", issue_cyc_q.size(), 32'd2);
    chk("t1_gap", (issue_cyc_q.size() >= 2) ? issue_cyc_q[1] - issue_cyc_q[0] : -1, 32'd1);
    chk("t1_stall_cycles", stall_obs, 32'd0);

    // 2: RAW on x8 -> dependent issues PIPE_DEPTH+1 cycles later
    clear_obs();
    push(ADD, 1'b1);
    push(SUB, 1'b1);
    in_valid = 1'b0;
    wait_idle();
    chk("t2_issue_count", issue_cyc_q.size(), 32'd2);
    chk("t2_gap", (issue_cyc_q.size() >= 2) ? issue_cyc_q[1] - issue_cyc_q[0] : -1, 32'd4);
    chk("t2_stall_cycles", stall_obs, 32'd3);

    // 3: illegal head is dropped, next instruction follows one cycle later
    clear_obs();
    push(ILL, 1'b0);
    push(ADD, 1'b1);
    in_valid = 1'b0;
    wait_idle();
    chk("t3_drop_pulses", drop_obs, 32'd1);
    chk("t3_issue_count", issue_cyc_q.size(), 32'd1);
    chk("t3_issue_after_drop", (issue_cyc_q.size() >= 1) ? issue_cyc_q[0] - drop_cyc : -1, 32'd1);

    // 4: hold with run=0, fill to full, then drain in order
    clear_obs();
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(mk(7'h03, 5'(16 + i), 3'(i % 3), 5'd2, 5'd3), (i < 4));
    end
    in_valid = 1'b0;
    chk("t4_in_ready_full", {31'd0, in_ready}, 32'd0);
    chk("t4_no_issue_on_hold", issue_cyc_q.size(), 32'd0);
    run = 1'b1;
    step();
    chk("t4_in_ready_after_pop", {31'd0, in_ready}, 32'd1);
    wait_idle();
    chk("t4_issue_count", issue_cyc_q.size(), 32'd4);
    chk("t4_span", (issue_cyc_q.size() >= 4) ? issue_cyc_q[3] - issue_cyc_q[0] : -1, 32'd3);

    // 5: flush with a same-cycle push drops everything
    clear_obs();
    run = 1'b0;
    for (int i = 0; i < 3; i++) push(mk(7'h0F, 5'(20 + i), 3'd1, 5'd4, 5'd5), 1'b0);
    flush = 1'b1;
    push(mk(7'h07, 5'd25, 3'd0, 5'd4, 5'd5), 1'b0);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t5_idle", {31'd0, idle}, 32'd1);
    run = 1'b1;
    repeat (6) step();
    chk("t5_issue_count", issue_cyc_q.size(), 32'd0);
    chk("t5_stall_cycles", stall_obs, 32'd0);

    // 6: reset in the middle of a RAW stall
    clear_obs();
    push(ADD, 1'b1);
    push(SUB, 1'b0);
    in_valid = 1'b0;
    n = 0;
    while (!stall && n < 20) begin
      step();
      n++;
    end
    chk("t6_stall_seen", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    step();
    chk("t6_issue_valid", {31'd0, issue_valid}, 32'd0);
    chk("t6_issue_instr", issue_instr, NOP);
    chk("t6_stall", {31'd0, stall}, 32'd0);
    chk("t6_illegal_drop", {31'd0, illegal_drop}, 32'd0);
    chk("t6_idle", {31'd0, idle}, 32'd1);
    chk("t6_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    repeat (8) step();
    chk("t6_issue_count", issue_cyc_q.size(), 32'd1);
    chk("t6_exp_queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
